// File: rtl/gray_fifo_ptr_ctrl.sv
// Single-clock FIFO pointer controller with registered Gray copies of the write/read pointers.
// Optional almost_full/almost_empty flags are enabled by defining GFPC_ALMOST_EN.
module gray_fifo_ptr_ctrl #(
  parameter int ADDR_WIDTH = 4,
  parameter int AF_LEVEL   = 12,
  parameter int AE_LEVEL   = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic [ADDR_WIDTH-1:0] raddr,
  output logic [ADDR_WIDTH:0]   wptr_gray,
  output logic [ADDR_WIDTH:0]   rptr_gray,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  full,
`ifdef GFPC_ALMOST_EN
  output logic                  almost_full,
  output logic                  almost_empty,
`endif
  output logic                  empty
);

  localparam int PW = ADDR_WIDTH + 1;

  // The full compare needs two distinct top bits plus a remainder, and the thresholds must be ordered.
  if (ADDR_WIDTH < 2 || AE_LEVEL >= AF_LEVEL || AF_LEVEL > (2 ** ADDR_WIDTH)) begin : g_bad_cfg
    $error("gray_fifo_ptr_ctrl: illegal parameter combination");
  end

  function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  logic [PW-1:0] wbin_q, wbin_d, rbin_q, rbin_d;
  logic [PW-1:0] wgray_q, wgray_d, rgray_q, rgray_d;
  logic [PW-1:0] count_q, count_d;
  logic          full_q, full_d, empty_q, empty_d;
  logic          push_s, pop_s;

  assign push_s = wr_valid & ~full_q;
  assign pop_s  = rd_ready & ~empty_q;

  // Next pointer state; flags are computed from the next Gray values so they land on the same edge.
  always_comb begin
    wbin_d  = wbin_q;
    rbin_d  = rbin_q;
    if (push_s) begin
      wbin_d = wbin_q + {{(PW-1){1'b0}}, 1'b1};
    end else begin
      wbin_d = wbin_q;
    end
    if (pop_s) begin
      rbin_d = rbin_q + {{(PW-1){1'b0}}, 1'b1};
    end else begin
      rbin_d = rbin_q;
    end
    wgray_d = bin2gray(wbin_d);
    rgray_d = bin2gray(rbin_d);
    count_d = wbin_d - rbin_d;
    empty_d = (wgray_d == rgray_d);
    full_d  = (wgray_d[PW-1:PW-2] == ~rgray_d[PW-1:PW-2]) &&
              (wgray_d[PW-3:0] == rgray_d[PW-3:0]);
  end

  // Pointer, Gray and occupancy registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wbin_q  <= {PW{1'b0}};
      rbin_q  <= {PW{1'b0}};
      wgray_q <= {PW{1'b0}};
      rgray_q <= {PW{1'b0}};
      count_q <= {PW{1'b0}};
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      wbin_q  <= wbin_d;
      rbin_q  <= rbin_d;
      wgray_q <= wgray_d;
      rgray_q <= rgray_d;
      count_q <= count_d;
      full_q  <= full_d;
      empty_q <= empty_d;
    end
  end

`ifdef GFPC_ALMOST_EN
  localparam logic [PW-1:0] AF_L = PW'(AF_LEVEL);
  localparam logic [PW-1:0] AE_L = PW'(AE_LEVEL);
  logic almost_full_q, almost_empty_q;

  // Threshold flags track count on the same edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      almost_full_q  <= 1'b0;
      almost_empty_q <= 1'b1;
    end else begin
      almost_full_q  <= (count_d >= AF_L);
      almost_empty_q <= (count_d <= AE_L);
    end
  end

  assign almost_full  = almost_full_q;
  assign almost_empty = almost_empty_q;
`endif

  assign wr_ready  = ~full_q;
  assign rd_valid  = ~empty_q;
  assign full      = full_q;
  assign empty     = empty_q;
  assign count     = count_q;
  assign wptr_gray = wgray_q;
  assign rptr_gray = rgray_q;
  assign waddr     = wbin_q[ADDR_WIDTH-1:0];
  assign raddr     = rbin_q[ADDR_WIDTH-1:0];

endmodule

// File: tb/tb_gray_fifo_ptr_ctrl.sv
// Randomised bench for gray_fifo_ptr_ctrl against a counter/queue occupancy model.
module tb_gray_fifo_ptr_ctrl;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int AF    = 12;
  localparam int AE    = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          wr_valid = 1'b0;
  logic          rd_ready = 1'b0;
  logic          wr_ready, rd_valid, full, empty;
  logic [AW-1:0] waddr, raddr;
  logic [AW:0]   wptr_gray, rptr_gray, count;
`ifdef GFPC_ALMOST_EN
  logic          almost_full, almost_empty;
`endif

  gray_fifo_ptr_ctrl #(.ADDR_WIDTH(AW), .AF_LEVEL(AF), .AE_LEVEL(AE)) dut (
    .clk(clk), .reset(reset), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .waddr(waddr), .raddr(raddr),
    .wptr_gray(wptr_gray), .rptr_gray(rptr_gray), .count(count), .full(full),
`ifdef GFPC_ALMOST_EN
    .almost_full(almost_full), .almost_empty(almost_empty),
`endif
    .empty(empty)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  // Model: total words accepted on each side since reset, plus the addresses still held.
  int wr_cnt = 0;
  int rd_cnt = 0;
  int addr_q[$];
  logic [AW:0] prev_w = '0;
  logic [AW:0] prev_r = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int gray_of(input int b);
    return (b ^ (b >> 1)) & 31;
  endfunction

  task automatic model_reset();
    wr_cnt = 0;
    rd_cnt = 0;
    addr_q.delete();
    prev_w = '0;
    prev_r = '0;
  endtask

  task automatic check_all();
    int occ;
    occ = wr_cnt - rd_cnt;
    check("count", 32'(count), 32'(occ));
    check("full", 32'(full), 32'(occ == DEPTH));
    check("empty", 32'(empty), 32'(occ == 0));
    check("wr_ready", 32'(wr_ready), 32'(occ != DEPTH));
    check("rd_valid", 32'(rd_valid), 32'(occ != 0));
    check("waddr", 32'(waddr), 32'(wr_cnt % DEPTH));
    check("raddr", 32'(raddr), 32'(rd_cnt % DEPTH));
    check("wptr_gray", 32'(wptr_gray), 32'(gray_of(wr_cnt % 32)));
    check("rptr_gray", 32'(rptr_gray), 32'(gray_of(rd_cnt % 32)));
    check("wgray_step", 32'($countones(wptr_gray ^ prev_w) <= 1), 32'd1);
    check("rgray_step", 32'($countones(rptr_gray ^ prev_r) <= 1), 32'd1);
`ifdef GFPC_ALMOST_EN
    check("almost_full", 32'(almost_full), 32'(occ >= AF));
    check("almost_empty", 32'(almost_empty), 32'(occ <= AE));
`endif
    prev_w = wptr_gray;
    prev_r = rptr_gray;
  endtask

  // Drive one cycle from the negedge, update the model at the edge, check at the next negedge.
  task automatic step(input logic wv, input logic rr);
    int  occ;
    int  exp_addr;
    bit  do_push, do_pop;
    wr_valid = wv;
    rd_ready = rr;
    occ      = wr_cnt - rd_cnt;
    do_push  = wv && (occ < DEPTH);
    do_pop   = rr && (occ > 0);
    if (do_pop) begin
      exp_addr = addr_q.pop_front();
      check("raddr_fifo_order", 32'(raddr), 32'(exp_addr));
    end
    @(posedge clk);
    if (do_push) begin
      addr_q.push_back(wr_cnt % DEPTH);
      wr_cnt++;
    end
    if (do_pop) rd_cnt++;
    @(negedge clk);
    check_all();
  endtask

  initial begin
    int pw, pr;
    // Power-on reset, then idle.
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0);
    check("reset_count_lit", 32'(count), 32'd0);
    check("reset_empty_lit", 32'(empty), 32'd1);
    check("reset_wgray_lit", 32'(wptr_gray), 32'd0);

    // Fill to 16, then one extra push that must be ignored.
    for (int i = 0; i < DEPTH + 1; i++) step(1'b1, 1'b0);
    check("fill_count_lit", 32'(count), 32'd16);
    check("fill_full_lit", 32'(full), 32'd1);
    check("fill_wr_ready_lit", 32'(wr_ready), 32'd0);
    check("fill_wgray_lit", 32'(wptr_gray), 32'b11000);
    check("fill_rgray_lit", 32'(rptr_gray), 32'd0);

    // Push+pop every cycle starting from full: first pop drains one, then both advance.
    for (int i = 0; i < 40; i++) step(1'b1, 1'b1);
    check("pp_count_lit", 32'(count), 32'd15);
    check("pp_waddr_lit", 32'(waddr), 32'(55 % 16));

    // Randomised traffic under varying write/read pressure.
    for (int blk = 0; blk < 4; blk++) begin
      pw = (blk == 0) ? 50 : (blk == 1) ? 85 : (blk == 2) ? 25 : 60;
      pr = (blk == 0) ? 50 : (blk == 1) ? 30 : (blk == 2) ? 80 : 60;
      for (int i = 0; i < 200; i++)
        step(1'($urandom_range(99) < pw), 1'($urandom_range(99) < pr));
    end

    // Drain (bounded), then fill to 9 and reset mid-burst.
    for (int i = 0; i < 40 && (wr_cnt - rd_cnt) > 0; i++) step(1'b0, 1'b1);
    check("drain_empty", 32'(empty), 32'd1);
    for (int i = 0; i < 9; i++) step(1'b1, 1'b0);
    check("pre_reset_count_lit", 32'(count), 32'd9);
    wr_valid = 1'b1;
    #1 reset = 1'b1;
    #1;
    model_reset();
    check_all();
    check("mid_reset_count_lit", 32'(count), 32'd0);
    check("mid_reset_rgray_lit", 32'(rptr_gray), 32'd0);
    @(negedge clk);
    check_all();
    reset = 1'b0;
    wr_valid = 1'b0;

`ifdef GFPC_ALMOST_EN
    for (int i = 0; i < 12; i++) step(1'b1, 1'b0);
    check("af_at_12_lit", 32'(almost_full), 32'd1);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1);
    check("ae_at_2_lit", 32'(almost_empty), 32'd1);
`endif
    for (int i = 0; i < 20; i++) step(1'($urandom_range(1)), 1'($urandom_range(1)));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
